// File: rtl/sum_accumulator_pkg.sv
// rtl/sum_accumulator_pkg.sv - shared widths and FSM state encoding for sum_accumulator
//
// Purpose: default widths used by the interface and the top, and the state
// encoding of the block-accumulation FSM.
//   SUM_W_DEF : width of the incoming signed sum (adder output width)
//   ACC_W_DEF : width of the signed saturating accumulator / block result
//   LEN_W_DEF : width of the block-length configuration and sample counter

package sum_accumulator_pkg;

    localparam int SUM_W_DEF = 33;
    localparam int ACC_W_DEF = 40;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - sample-in / block-result-out handshake bundle
//
// Purpose: groups the block-length configuration, the incoming sum stream and
// the outgoing block-result stream of sum_accumulator.
//   cfg_len   : samples per block, sampled with the first sample of a block
//   in_valid  : in_sum is valid
//   in_ready  : accumulator can accept a sample
//   in_sum    : signed sum from the adder
//   out_valid : block result is valid
//   out_ready : consumer takes the block result
//   out_acc   : signed block result
//   out_ovf   : saturation occurred at least once in the block
// Modports: master = producer/consumer side, slave = the accumulator.

interface sum_accumulator_if
    import sum_accumulator_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
);

    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output cfg_len,
        output in_valid,
        output in_sum,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_acc,
        input  out_ovf
    );

    modport slave (
        input  cfg_len,
        input  in_valid,
        input  in_sum,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_acc,
        output out_ovf
    );

endinterface

// File: rtl/sum_accumulator_sat_add.sv
// rtl/sum_accumulator_sat_add.sv - combinational signed saturating adder
//
// Purpose: y = clamp(a + b) to the signed ACC_W range; sat flags a clamp.
//   a, b : signed ACC_W-bit operands
//   y    : signed ACC_W-bit saturated sum
//   sat  : 1 when the true sum was outside the representable range

module sat_add #(
    parameter int ACC_W = 40
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] y,
    output logic                    sat
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;

    always_comb begin
        sum_wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        sat      = 1'b0;
        y        = sum_wide[ACC_W-1:0];
        // The extra bit disagrees with the ACC_W sign bit exactly when the
        // true sum left the signed range; the extra bit gives the direction.
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sat = 1'b1;
            y   = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - saturating block accumulator behind the 32-bit signed adder
//
// Purpose: accepts signed sums over a valid/ready handshake, accumulates a
// block of cfg_len samples (0 treated as 1) into a saturating signed
// accumulator, then holds the result until the consumer takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : sum_accumulator_if.slave (cfg_len, in_*, out_*)
// in_ready / out_valid are decoded from the registered state only, so there
// is no combinational path from in_valid or out_ready to any output.

module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sum_accumulator_if.slave      bus
);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    ovf_q, ovf_d;

    logic                    in_ready;
    logic                    accept;
    logic [LEN_W-1:0]        eff_len;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] add_y;
    logic                    add_sat;

    assign in_ready = (state_q != ST_HOLD);
    assign accept   = bus.in_valid & in_ready;
    assign sum_ext  = ACC_W'($signed(bus.in_sum));
    // A zero length would never complete a block; treat it as one sample.
    assign eff_len  = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (sum_ext),
        .y   (add_y),
        .sat (add_sat)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    len_d   = eff_len;
                    acc_d   = sum_ext;
                    cnt_d   = LEN_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (eff_len == LEN_W'(1)) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = add_y;
                    cnt_d = cnt_q + LEN_W'(1);
                    ovf_d = ovf_q | add_sat;
                    if (cnt_d == len_q) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Handoff cycle never accepts a sample: in_ready is low here.
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule
